// File: rtl/fir_pkg.sv
// Shared FIR numeric constants and the requantisation helper used by the FIR core
// and the output collector.
package fir_pkg;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_FRAC_W = 12;
  localparam int COL_OUT_W  = 12;

  // Round-half-up on the dropped LSBs, then clamp to a signed out_w range.
  // Widths up to 32 bits; the caller truncates the result to out_w.
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] x,
                                                   input int shift, input int out_w);
    logic signed [31:0] r, hi, lo;
    r  = (x >>> shift) + signed'({31'd0, x[shift-1]});
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (r > hi)      return hi;
    else if (r < lo) return lo;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head is visible on o_rdata while non-empty, zero otherwise.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_level = wr_q - rd_q;
  assign o_rdata = o_empty ? '0 : mem_q[rd_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    do_pop  = i_pop && !o_empty;
    do_push = i_push && (!o_full || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/fir_out_collector.sv
// FIR output receive end: decimate, requantise S4.12 -> S4.8 with rounding and
// saturation, buffer in a FIFO and hand off on valid/ready with a sticky overflow flag.
module fir_out_collector
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int OUT_W  = COL_OUT_W,
  parameter int DECIM  = 2,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_valid,
  output logic [OUT_W-1:0]         o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf
);
  localparam int S    = DATA_W - OUT_W;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]  phase_q, phase_d;
  logic             q_vld_q, q_vld_d;
  logic [OUT_W-1:0] q_data_q, q_data_d;
  logic             ovf_q, ovf_d;
  logic             keep, pop, drop, full, empty;

  assign o_valid    = !empty;
  assign o_overflow = ovf_q;
  assign pop        = o_valid && i_ready;
  // Full implies non-empty, so a pop here always frees a slot for the pending write.
  assign drop       = q_vld_q && full && !pop;

  always_comb begin
    keep    = i_enable && i_valid && (phase_q == '0);
    phase_d = phase_q;
    if (!i_enable)
      phase_d = '0;
    else if (i_valid)
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
    q_vld_d  = keep;
    q_data_d = OUT_W'(round_sat(32'(i_data), S, OUT_W));
    ovf_d    = drop || (ovf_q && !i_clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      phase_q  <= '0;
      q_vld_q  <= 1'b0;
      q_data_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      q_vld_q  <= q_vld_d;
      q_data_q <= q_data_d;
      ovf_q    <= ovf_d;
    end
  end

  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (q_vld_q),
    .i_wdata (q_data_q),
    .i_pop   (pop),
    .o_rdata (o_data),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_level)
  );
endmodule
